// File: rtl/mem_access_controller.sv
// mem_access_controller: splits 32-bit loads/stores into two 16-bit SRAM accesses and stalls the pipeline meanwhile
// Ports:
//   clk, rst (async, active-high)
//   rd_en, wr_en      load/store request; rd_en wins when both are high
//   address           byte address, word-aligned; address[18:2] selects the word
//   write_data        store data
//   read_data         load result, held until the next read completes
//   ready             1 = pipeline may advance, 0 = freeze
//   sram_addr         half-word address ({word,0} low half, {word,1} high half)
//   sram_dq_out       SRAM write data
//   sram_dq_oe        drive enable for the SRAM data bus
//   sram_dq_in        SRAM read data
//   sram_we_n         SRAM write strobe, active-low
// Optional feature: define LAST_READ_CACHE_EN to answer a repeated read of the
// last completed read address in zero cycles without touching the SRAM.
module mem_access_controller #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);
    state_t      state;
    logic [3:0]  cnt;
    logic [16:0] word_addr;
    logic [31:0] data;
    logic        op_wr;
    logic        req;
    logic        last;
    logic        hit;
    logic        unused_addr_bits;
    assign req              = rd_en | wr_en;
    assign last             = cnt == LAST_CNT;
    assign unused_addr_bits = ^{address[31:19], address[1:0]};
    assign ready            = state == IDLE ? (hit | !req) : state == DONE;
`ifdef LAST_READ_CACHE_EN
    logic        valid;
    logic [16:0] cache_addr;
    assign hit = valid && rd_en && address[18:2] == cache_addr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid      <= 1'b0;
            cache_addr <= '0;
        end else if (state == IDLE && wr_en && !rd_en) begin
            valid <= 1'b0;
        end else if (state == HIGH && last && !op_wr) begin
            valid      <= 1'b1;
            cache_addr <= word_addr;
        end
    end
`else
    assign hit = 1'b0;
`endif
    // Strobe/address outputs are registered: each branch loads the values for
    // the cycle that follows the edge. we_n rises on the last cycle of each
    // half so the write completes before the address changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            word_addr   <= '0;
            data        <= '0;
            op_wr       <= 1'b0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: if (req && !hit) begin
                    state       <= LOW;
                    cnt         <= '0;
                    word_addr   <= address[18:2];
                    data        <= write_data;
                    op_wr       <= !rd_en;
                    sram_addr   <= {address[18:2], 1'b0};
                    sram_dq_out <= write_data[15:0];
                    sram_dq_oe  <= !rd_en;
                    sram_we_n   <= rd_en;
                end
                LOW: if (last) begin
                    state       <= HIGH;
                    cnt         <= '0;
                    sram_addr   <= {word_addr, 1'b1};
                    sram_dq_out <= data[31:16];
                    sram_we_n   <= !op_wr;
                    if (!op_wr) read_data[15:0] <= sram_dq_in;
                end else begin
                    cnt       <= cnt + 4'd1;
                    sram_we_n <= !op_wr || (cnt + 4'd1 == LAST_CNT);
                end
                HIGH: if (last) begin
                    state       <= DONE;
                    cnt         <= '0;
                    sram_addr   <= '0;
                    sram_dq_out <= '0;
                    sram_dq_oe  <= 1'b0;
                    sram_we_n   <= 1'b1;
                    if (!op_wr) read_data[31:16] <= sram_dq_in;
                end else begin
                    cnt       <= cnt + 4'd1;
                    sram_we_n <= !op_wr || (cnt + 4'd1 == LAST_CNT);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_controller.sv
// tb_mem_access_controller: self-checking bench for mem_access_controller with a behavioural SRAM
module tb_mem_access_controller;
    localparam int W = 2;
`ifdef LAST_READ_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif
    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        hit;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb[$];
    logic [15:0] mem [0:1023];
    vec_t        tbl [12];
    always #5 clk = ~clk;
    mem_access_controller #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );
    assign sram_dq_in = mem[sram_addr[9:0]];
    always @(posedge clk) if (!sram_we_n) mem[sram_addr[9:0]] <= sram_dq_out;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [63:0] mon(input logic w);
        return {27'h0, ready, sram_dq_oe, sram_we_n, sram_addr, w ? sram_dq_out : 16'h0};
    endfunction
    localparam logic [63:0] IDLE_OUT = {27'h0, 1'b1, 1'b0, 1'b1, 18'h0, 16'h0};
    // Called just after a rising edge with the controller in IDLE; returns
    // just after the rising edge that brings it back to IDLE.
    task automatic access(input vec_t v);
        logic [16:0] wa;
        logic        w;
        logic        h;
        logic        half;
        int          idx;
        logic [63:0] exp;
        wa = v.addr[18:2];
        w  = v.wr && !v.rd;
        h  = CACHE && v.hit;
        rd_en = v.rd; wr_en = v.wr; address = v.addr; write_data = v.wdata;
        sb.push_back(v.exp_rd);
        @(negedge clk);
        chk("idle_ready", {63'h0, ready}, {63'h0, h});
        if (h) begin
            chk("hit_no_sram", mon(1'b0), IDLE_OUT);
            chk("hit_read_data", {32'h0, read_data}, {32'h0, sb.pop_front()});
            @(posedge clk); #1;
            rd_en = 0; wr_en = 0;
            @(negedge clk);
            chk("hit_stays_idle", mon(1'b0), IDLE_OUT);
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        rd_en = 0; wr_en = 0;
        for (int k = 1; k <= 2 * W + 1; k++) begin
            @(negedge clk);
            half = k > W;
            idx  = (k - 1) % W;
            exp  = k <= 2 * W
                 ? {27'h0, 1'b0, w, !(w && idx != W - 1), wa, half,
                    w ? (half ? v.wdata[31:16] : v.wdata[15:0]) : 16'h0}
                 : IDLE_OUT;
            chk($sformatf("addr%h_cyc%0d", v.addr, k), mon(w), exp);
            if (ready) begin
                chk("read_data", {32'h0, read_data}, {32'h0, sb.pop_front()});
                break;
            end
        end
        if (sb.size() != 0) begin
            chk("ready_timeout", 64'h0, 64'h1);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask
    initial begin
        logic [7:0]  rdy;
        logic [17:0] a7;
        vec_t        v;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
        tbl[0]  = '{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 32'h20,       32'hCAFEF00D, 32'hDEADBEEF, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 32'h24,       32'h12345678, 32'hDEADBEEF, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 32'h24,       32'hFFFFFFFF, 32'h12345678, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 32'h20,       32'h0,        32'hCAFEF00D, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 32'h24,       32'h0,        32'h12345678, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 32'h7FFFC,    32'hA5A55A5A, 32'h12345678, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 32'h7FFFC,    32'h0,        32'hA5A55A5A, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 32'hABC7FFFC, 32'h0,        32'hA5A55A5A, 1'b1};
        rst = 1; rd_en = 0; wr_en = 0; address = 0; write_data = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", mon(1'b1), IDLE_OUT);
        chk("reset_read_data", {32'h0, read_data}, 64'h0);
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 12; i++) access(tbl[i]);
        // Asynchronous reset in the second HIGH cycle of a write
        rd_en = 0; wr_en = 1; address = 32'h30; write_data = 32'h11112222;
        @(posedge clk); #1;
        wr_en = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_high", {46'h0, sram_addr}, {46'h0, 18'd25});
        #1 rst = 1;
        #1;
        chk("async_reset_outputs", mon(1'b1), IDLE_OUT);
        chk("async_reset_read_data", {32'h0, read_data}, 64'h0);
        @(posedge clk); #1;
        rst = 0;
        v = '{1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
        access(v);
        // rd_en held for 8 cycles: one completed access, then a fresh one
        rd_en = 1; address = 32'h20;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rdy[c] = ready;
            if (c == 7) a7 = sram_addr;
            if (c < 7) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        rd_en = 0;
        chk("hold_ready_pattern", {56'h0, rdy}, CACHE ? 64'hE0 : 64'h20);
        chk("hold_second_access", {46'h0, a7}, CACHE ? 64'h0 : 64'd16);
        chk("hold_read_data", {32'h0, read_data}, 64'hCAFEF00D);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
